// File: rtl/romcode_pkg.sv
// Shared types and widths for the firmware BRAM port arbiter.
package romcode_pkg;

  localparam int unsigned ROMCODE_ADDR_W = 32;
  localparam int unsigned ROMCODE_DATA_W = 32;

  typedef enum logic {
    OWN_FLASH  = 1'b0,
    OWN_LOADER = 1'b1
  } romcode_owner_e;

  typedef struct packed {
    logic           valid;
    romcode_owner_e owner;
  } romcode_pipe_t;

endpackage

// File: rtl/romcode_starve_ctr.sv
// Saturating count of consecutive denied loader cycles; flags when the loader must be let through.
module romcode_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic l_req,
  input  logic l_gnt,
  output logic starve
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!l_req || l_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != Limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve = (cnt_q == Limit);

endmodule

// File: rtl/romcode_port_arb.sv
// Arbitrates the flash-emulator fetch path and the loader/debug port onto the single-port
// firmware BRAM. Define ROMCODE_ARB_STARVE_EN to bound how long the loader can be denied.
module romcode_port_arb
  import romcode_pkg::*;
#(
  parameter int unsigned ADDR_W       = ROMCODE_ADDR_W,
  parameter int unsigned DATA_W       = ROMCODE_DATA_W,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic [3:0]        l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] romcode_Addr_A,
  output logic              romcode_EN_A,
  output logic [3:0]        romcode_WEN_A,
  output logic [DATA_W-1:0] romcode_Din_A,
  input  logic [DATA_W-1:0] romcode_Dout_A,
  output logic              romcode_Clk_A,
  output logic              romcode_Rst_A
);

  logic starve;

`ifdef ROMCODE_ARB_STARVE_EN
  romcode_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .l_req (l_req),
    .l_gnt (l_gnt),
    .starve(starve)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign starve = 1'b0;
`endif

  // Grants are gated by reset so nothing is accepted while the BRAM is held.
  assign f_gnt = ap_rst & f_req & ~starve;
  assign l_gnt = ap_rst & l_req & (starve | ~f_req);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [3:0]        wen_q, wen_d;
  logic              en_q, en_d;
  romcode_pipe_t     pipe_q [2];
  romcode_pipe_t     pipe_d;
  logic [DATA_W-1:0] f_rdata_q, l_rdata_q;

  always_comb begin
    addr_d = addr_q;
    din_d  = din_q;
    wen_d  = 4'h0;
    en_d   = 1'b0;
    if (f_gnt) begin
      addr_d = f_addr;
      en_d   = 1'b1;
    end else if (l_gnt) begin
      addr_d = l_addr;
      din_d  = l_wdata;
      wen_d  = l_we;
      en_d   = 1'b1;
    end
  end

  // Loader writes occupy the port but never come back on the return path.
  always_comb begin
    pipe_d.valid = f_gnt | (l_gnt & (l_we == 4'h0));
    pipe_d.owner = l_gnt ? OWN_LOADER : OWN_FLASH;
  end

  assign f_rvalid = pipe_q[1].valid & (pipe_q[1].owner == OWN_FLASH);
  assign l_rvalid = pipe_q[1].valid & (pipe_q[1].owner == OWN_LOADER);

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      addr_q    <= '0;
      din_q     <= '0;
      wen_q     <= 4'h0;
      en_q      <= 1'b0;
      pipe_q[0] <= '0;
      pipe_q[1] <= '0;
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      addr_q    <= addr_d;
      din_q     <= din_d;
      wen_q     <= wen_d;
      en_q      <= en_d;
      pipe_q[0] <= pipe_d;
      pipe_q[1] <= pipe_q[0];
      if (f_rvalid) f_rdata_q <= romcode_Dout_A;
      if (l_rvalid) l_rdata_q <= romcode_Dout_A;
    end
  end

  // BRAM data is live only in the pulse cycle; the held copy covers the gaps.
  assign f_rdata = f_rvalid ? romcode_Dout_A : f_rdata_q;
  assign l_rdata = l_rvalid ? romcode_Dout_A : l_rdata_q;

  assign romcode_Addr_A = addr_q;
  assign romcode_EN_A   = en_q;
  assign romcode_WEN_A  = wen_q;
  assign romcode_Din_A  = din_q;
  assign romcode_Clk_A  = ap_clk;
  assign romcode_Rst_A  = ~ap_rst;

endmodule

// File: doc/romcode_port_arb.md
# romcode_port_arb

- Two-requester arbiter for the single-port firmware BRAM (`romcode_*` port) behind the caravel flash emulation.
- Requesters:
  - the SPI flash emulator's instruction-fetch read path, which has priority;
  - a loader/debug port that preloads or patches firmware, and reads it back, during simulation and FPGA bring-up.
- Drives the BRAM through registered outputs and routes read data back to whichever requester issued the read.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width on both requesters and the BRAM port
- `DATA_W`, 32, data width; the BRAM word size
- `STARVE_LIMIT`, 8, consecutive denied loader cycles before the loader is forced through (only used with `ROMCODE_ARB_STARVE_EN`)

Ports:
- `ap_clk`  in  1  sole clock
- `ap_rst`  in  1  reset, asynchronous assert, active-low
- `f_req`  in  1  flash read request; held until granted
- `f_addr`  in  `ADDR_W`  flash read byte address
- `f_gnt`  out  1  flash request accepted this cycle
- `f_rvalid`  out  1  one-cycle pulse, `f_rdata` valid
- `f_rdata`  out  `DATA_W`  flash read data
- `l_req`  in  1  loader request; held until granted
- `l_we`  in  4  loader byte write enables; 0 = read
- `l_addr`  in  `ADDR_W`  loader byte address
- `l_wdata`  in  `DATA_W`  loader write data
- `l_gnt`  out  1  loader request accepted this cycle
- `l_rvalid`  out  1  one-cycle pulse, `l_rdata` valid (reads only)
- `l_rdata`  out  `DATA_W`  loader read data
- `romcode_Addr_A`  out  `ADDR_W`  BRAM address (registered)
- `romcode_EN_A`  out  1  BRAM enable (registered)
- `romcode_WEN_A`  out  4  BRAM byte write enables (registered)
- `romcode_Din_A`  out  `DATA_W`  BRAM write data (registered)
- `romcode_Dout_A`  in  `DATA_W`  BRAM read data, one cycle after `EN`
- `romcode_Clk_A`  out  1  equals `ap_clk`
- `romcode_Rst_A`  out  1  equals `~ap_rst` (BRAM reset is active-high)

## Operation
- **Grant (combinational, same cycle as request):**
  - default is fixed priority: `f_gnt = f_req`, and `l_gnt = l_req & ~f_req`;
  - override: when the starve flag is set, `l_gnt = l_req`, and `f_gnt = 0` that cycle;
  - at most one grant per cycle; a granted requester may issue back-to-back, one access per cycle.
- **Port register:** on any grant, capture the winner's address, write enables (0 for flash), write data and `EN=1`. With no grant, `EN=0` and `WEN=0`; address and data hold their last value.
- **Owner pipeline:** a 2-stage shift tracks each granted read, recording its owner and a read flag. Loader writes occupy the port but produce no `rvalid`.
- **Return path:** at stage 2, pulse the owner's `rvalid` and present `romcode_Dout_A` on its `rdata`. `rdata` holds its value between pulses.
- **Starve counter:**
  - width `$clog2(STARVE_LIMIT+1)`;
  - increments each cycle `l_req & ~l_gnt`;
  - clears on `l_gnt` or `~l_req`;
  - saturates at `STARVE_LIMIT`;
  - starve flag = (count == `STARVE_LIMIT`).
- **Reset (`ap_rst` low, at any time):**
  - all `romcode_*` registered outputs go to 0;
  - the owner pipeline is flushed, so in-flight reads never return;
  - `rvalid`/`rdata` = 0 and the counter = 0;
  - grants are forced to 0 while reset is asserted.

## Timing
- Cycle N: `req` and `gnt` are both high.
- Cycle N+1: `romcode_EN_A` is high with the captured address.
- Cycle N+2: `rvalid` is high with the BRAM data. Read latency is 2 cycles.
- Throughput: 1 access per cycle in aggregate.
- A loader write at N is committed to the BRAM at the N+1 clock edge. A flash read of the same address granted at N+1 returns the new data (there is no read-before-write hazard across accesses).
- Simultaneous requests with the starve flag clear: flash wins and the loader counter increments.

## Configuration
- Macro: `ROMCODE_ARB_STARVE_EN`.
- Defined: the starve counter and override are active. The loader is guaranteed a grant within `STARVE_LIMIT+1` cycles under continuous flash requests.
- Undefined: strict flash priority; no counter logic and `STARVE_LIMIT` is ignored. The loader can starve indefinitely.

## Structure
- Shared package `romcode_pkg` holds:
  - `ROMCODE_ADDR_W` and `ROMCODE_DATA_W` constants;
  - a `romcode_owner_e` enum {`OWN_FLASH`, `OWN_LOADER`};
  - a `romcode_pipe_t` struct {valid, owner}.
- One sub-module, `romcode_starve_ctr`: the saturating counter and flag, instantiated only under the macro.

## Test plan
- **Reset values:** hold reset for 5 cycles, then release. Require all outputs 0, `romcode_Rst_A`=1 during reset and 0 after, and no grant while in reset.
- **Flash read:** preload word 0x0000_0010 = 0xDEAD_BEEF. Issue `f_req` with `f_addr`=0x10 at N. Require `f_gnt`@N, `EN`@N+1 with addr 0x10, and `f_rvalid`@N+2 with `f_rdata`=0xDEAD_BEEF.
- **Write then read:** loader writes 0x1234_5678 to 0x20 (`l_we`=0xF), then reads 0x20. Require `l_rvalid` on the read only, with `l_rdata`=0x1234_5678. Repeat with `l_we`=0x1 and data 0xFF; the read must return 0x1234_56FF.
- **Contention, macro on:** hold `f_req` and `l_req` continuously with `STARVE_LIMIT`=8. Require `l_gnt` on the 9th cycle, `f_gnt`=0 on that cycle, then the flash resumes.
- **Contention, macro off:** same stimulus for 100 cycles. Require `l_gnt` never asserted and `f_rvalid` every cycle from the third onward.
- **Reset mid-read:** grant a flash read at N and assert reset at N+1. Require no `f_rvalid` at N+2 and `EN`=0 during reset.
